// File: rtl/tapper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : tapper_pkg                                                 |
// | Shared types and address-map constants for the Tapper download path. |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package tapper_pkg;

  // Destination of a downloaded byte
  typedef enum logic [1:0] {
    P1 = 2'd0,  // main/sound code, SDRAM port1
    P2 = 2'd1,  // sprite graphics, SDRAM port2
    BG = 2'd2   // bg/char graphics, BRAM download bus
  } region_t;

  // Download sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    FINISH   = 2'd3
  } state_t;

  // Default region bases, shared with emu
  localparam logic [24:0] c_sp_base = 25'h12000;
  localparam logic [24:0] c_bg_base = 25'h32000;

  // Map a byte address onto its destination region
  function automatic region_t region_of(input logic [24:0] addr,
                                        input logic [24:0] sp_base,
                                        input logic [24:0] bg_base);
    region_t r;
    if (addr < sp_base)      r = P1;
    else if (addr < bg_base) r = P2;
    else                     r = BG;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : toggle_hs                                                  |
// | Toggle req/ack handshake for one SDRAM port with an ack timeout.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module toggle_hs #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic busy,
  output logic timeout
);

  logic       r_req;
  logic       r_ack_fix;  // flipped on timeout so a lost ack no longer counts as outstanding
  logic [7:0] r_cnt;

  assign req     = r_req;
  assign busy    = r_req ^ ack ^ r_ack_fix;
  assign timeout = busy & (r_cnt == ACK_TIMEOUT);

  // Request toggle, ack shadow correction and saturating wait counter
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_req     <= 1'b0;
      r_ack_fix <= 1'b0;
      r_cnt     <= 8'd0;
    end else begin
      if (start) begin
        r_req <= ~r_req;
        r_cnt <= 8'd0;
      end else if (busy && (r_cnt != ACK_TIMEOUT)) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (timeout) r_ack_fix <= ~r_ack_fix;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_dl_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rom_dl_ctrl                                                |
// | ROM download sequencer: ioctl stream -> SDRAM ports / BRAM bus, and  |
// | game reset generation.                                               |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module rom_dl_ctrl
  import tapper_pkg::*;
#(
  parameter logic [24:0] SP_BASE     = c_sp_base,
  parameter logic [24:0] BG_BASE     = c_bg_base,
  parameter logic [15:0] HOLD_CYCLES = 16'hFFFF,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ext_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        dl_wr,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        dl_err
);

  state_t      r_state;
  region_t     r_sel;
  logic        r_wr_d, r_dl_d, r_fin_pend, r_wrote;
  logic [15:0] r_hold;

  region_t     w_region;
  logic        w_evt, w_dl_fall, w_dl_rise;
  logic        w_start1, w_start2, w_busy1, w_busy2, w_to1, w_to2;
  logic        w_busy, w_timeout, w_rst_terms;
  logic [18:0] w_sp_off;  // sprite offsets never exceed 19 bits
  logic [24:0] w_bg_off;

  assign w_evt     = ioctl_wr & ~r_wr_d;
  assign w_dl_fall = r_dl_d & ~ioctl_download;
  assign w_dl_rise = ~r_dl_d & ioctl_download;
  assign w_region  = region_of(ioctl_addr, SP_BASE, BG_BASE);
  assign w_sp_off  = 19'(ioctl_addr - SP_BASE);
  assign w_bg_off  = ioctl_addr - BG_BASE;

  // Start pulses are combinational so the req toggle lands one cycle after the event
  assign w_start1  = (r_state == IDLE) & w_evt & (w_region == P1);
  assign w_start2  = (r_state == IDLE) & w_evt & (w_region == P2);
  assign w_busy    = (r_sel == P2) ? w_busy2 : w_busy1;
  assign w_timeout = (r_sel == P2) ? w_to2 : w_to1;

  assign port1_we  = ioctl_download | (r_state != IDLE);
  assign port2_we  = ioctl_download | (r_state != IDLE);

  toggle_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs1 (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .start   (w_start1),
    .ack     (port1_ack),
    .req     (port1_req),
    .busy    (w_busy1),
    .timeout (w_to1)
  );

  toggle_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs2 (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .start   (w_start2),
    .ack     (port2_ack),
    .req     (port2_req),
    .busy    (w_busy2),
    .timeout (w_to2)
  );

  // Download sequencer: decode, issue, wait for ack, close the session
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_sel      <= P1;
      r_wr_d     <= 1'b0;
      r_dl_d     <= 1'b0;
      r_fin_pend <= 1'b0;
      r_wrote    <= 1'b0;
      ioctl_wait <= 1'b0;
      port1_a    <= '0;
      port1_ds   <= '0;
      port1_d    <= '0;
      port2_a    <= '0;
      port2_ds   <= '0;
      port2_d    <= '0;
      dl_wr      <= 1'b0;
      dl_addr    <= '0;
      dl_data    <= '0;
      rom_loaded <= 1'b0;
      dl_err     <= 1'b0;
    end else begin
      r_wr_d <= ioctl_wr;
      r_dl_d <= ioctl_download;
      dl_wr  <= 1'b0;
      if (w_dl_rise) r_wrote <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_evt) r_wrote <= 1'b1;
          if (w_evt && (w_region != BG)) begin
            r_state    <= ISSUE;
            r_sel      <= w_region;
            ioctl_wait <= 1'b1;
            if (w_region == P1) begin
              port1_a  <= ioctl_addr[23:1];
              port1_ds <= {ioctl_addr[0], ~ioctl_addr[0]};
              port1_d  <= {ioctl_dout, ioctl_dout};
            end else begin
              port2_a  <= {4'd0, w_sp_off[18:17], w_sp_off[14:0], w_sp_off[16]};
              port2_ds <= {w_sp_off[15], ~w_sp_off[15]};
              port2_d  <= {ioctl_dout, ioctl_dout};
            end
            if (w_dl_fall) r_fin_pend <= 1'b1;
          end else begin
            if (w_evt) begin
              dl_wr   <= 1'b1;
              dl_addr <= w_bg_off;
              dl_data <= ioctl_dout;
            end
            if (w_dl_fall || r_fin_pend) begin
              r_state    <= FINISH;
              r_fin_pend <= 1'b0;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT_ACK;
          if (w_dl_fall) r_fin_pend <= 1'b1;
        end
        WAIT_ACK: begin
          if (w_dl_fall) r_fin_pend <= 1'b1;
          if (!w_busy) begin
            r_state    <= IDLE;
            ioctl_wait <= 1'b0;
          end else if (w_timeout) begin
            dl_err     <= 1'b1;
            r_state    <= IDLE;
            ioctl_wait <= 1'b0;
          end
        end
        FINISH: begin
          if (r_wrote) rom_loaded <= 1'b1;
          r_wrote <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rst_terms = RESET | ext_reset | ioctl_download | ~rom_loaded;
  assign core_reset  = w_rst_terms | (r_hold != 16'd0);

  // Post-load reset hold: reload while any reset source is active, then count out
  always_ff @(posedge clk_sys) begin
    if (w_rst_terms)          r_hold <= HOLD_CYCLES;
    else if (r_hold != 16'd0) r_hold <= r_hold - 16'd1;
  end

endmodule
`default_nettype wire
